cnt_poll_master: RTL and testbench
==================================

Name: cnt_poll_master

Overview:
- Initiator side of the counter-readout request/response protocol: drives req/idx toward the readout mux and collects the returned data/valid responses.
- On start, sweeps every counter index once, captures each count into a snapshot register bank and accumulates their sum.
- Flags indices that never answer.
- Sits between the counter readout mux and any consumer of counter statistics (host register file, checker).

Parameters:
- NUM_CNT, 5, number of counters polled (indices 0..NUM_CNT-1)
- CNT_W, 5, width of one count value
- IDX_W, 3, width of idx; must satisfy 2**IDX_W >= NUM_CNT
- TIMEOUT, 8, cycles waited for valid after req before declaring the index dead
- SUM_W, 8, accumulator width; must be >= CNT_W + clog2(NUM_CNT)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when not busy
- idle  in  1  responder ready; req is only issued while idle=1
- valid  in  1  response strobe from the readout mux
- data  in  CNT_W  count returned with valid
- req  out  1  one-cycle request strobe
- idx  out  IDX_W  counter index being requested
- snap  out  NUM_CNT*CNT_W  captured counts; entry i at bits [i*CNT_W +: CNT_W]
- total  out  SUM_W  sum of all captured counts in the last sweep
- err_mask  out  NUM_CNT  bit i set = index i timed out in the last sweep
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (sync, active-high), sampled each edge, overrides everything including mid-sweep:
  - req=0, idx=0, snap=0, total=0, err_mask=0, busy=0, done=0
  - FSM to S_IDLE, timeout counter cleared
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE.
- S_IDLE:
  - start=1 moves to S_ISSUE.
  - Same cycle: idx<=0, total<=0, err_mask<=0, busy<=1.
  - snap keeps its old contents until overwritten entry by entry.
  - start while busy=1 is ignored.
- S_ISSUE:
  - If idle=1: req=1 for exactly this cycle; go to S_WAIT with the timeout counter cleared.
  - If idle=0: req=0; stay, with idx held.
- S_WAIT:
  - req=0; idx held stable.
  - valid=1: snap[idx]<=data; total<=total+data (zero-extended, no saturation; SUM_W sized so overflow is impossible); go to S_NEXT.
  - Otherwise the counter increments. On reaching TIMEOUT with no valid: snap[idx]<=0, err_mask[idx]<=1, go to S_NEXT.
  - valid and timeout in the same cycle: valid wins.
- S_NEXT:
  - idx==NUM_CNT-1: go to S_DONE.
  - Else: idx<=idx+1, go to S_ISSUE.
- S_DONE: done=1 for one cycle; busy<=0; idx<=0; go to S_IDLE.
- Response latency: valid is legal from 1 cycle after req up to TIMEOUT cycles after req. valid in the req cycle itself or outside S_WAIT is ignored, with no state change.
- Best-case sweep: start at cycle 0, then 3 cycles per index when valid arrives 1 cycle after req. done at cycle 1+3*NUM_CNT (16 for defaults).
- A late valid for a timed-out index that arrives while S_WAIT is pending for the next index is accepted as that next index's data. The responder guarantees this cannot happen when TIMEOUT exceeds its maximum latency.
- snap, total and err_mask are stable from done until the next start.
- idle dropping during S_WAIT has no effect; idle only gates req issue.

Decomposition:
- Shared package:
  - state encoding localparams S_IDLE..S_DONE
  - default NUM_CNT/CNT_W/IDX_W
  - snap slice helper
- Optional sub-module: cnt_poll_timer, a down-counter with load/clear/expired for TIMEOUT. Everything else stays in one module.

Test Plan:
- Responder returns data=3,7,0,31,12 one cycle after each req, idle=1 -> req pulses at idx 0..4; snap={12,31,0,7,3} (idx4..0); total=53; err_mask=0; done at cycle 16.
- idle held 0 for 4 cycles before the idx 2 request -> no req during those cycles; idx stays 2; results identical to the previous case; done delayed by 4 cycles.
- Index 3 never answers -> after TIMEOUT=8 cycles snap[3]=0, err_mask=5'b01000; sweep continues; total excludes index 3.
- valid asserted in the req cycle and again 2 cycles later with data=9 -> first ignored, second captured into snap[idx].
- reset pulsed while in S_WAIT for idx 2 -> next cycle all outputs 0, busy=0, no further req; a new start gives a clean full sweep.
- start pulsed twice during a sweep, plus a second sweep after done -> extra starts ignored; second sweep clears total/err_mask and overwrites snap.

Source files
------------

// File: rtl/cnt_poll_master_pkg.sv
// Shared types and defaults for the counter poll master.
package cnt_poll_master_pkg;

  localparam int unsigned DEF_NUM_CNT = 5;
  localparam int unsigned DEF_CNT_W   = 5;
  localparam int unsigned DEF_IDX_W   = 3;
  localparam int unsigned DEF_TIMEOUT = 8;
  localparam int unsigned DEF_SUM_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // LSB position of snapshot entry i in the flattened snap bus.
  function automatic int unsigned snap_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/cnt_poll_master_timer.sv
// Response timeout down-counter: load on request, decrement while waiting.
module cnt_poll_master_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(TIMEOUT);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  // Last permitted wait cycle: a missing valid here means the index is dead.
  assign expired_c = (count_q == TW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cnt_poll_master.sv
// Sweeps all counter indices over req/valid, snapshots each count and sums them.
module cnt_poll_master
  import cnt_poll_master_pkg::*;
#(
  parameter int unsigned NUM_CNT = DEF_NUM_CNT,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned SUM_W   = DEF_SUM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     idle,
  input  logic                     valid,
  input  logic [CNT_W-1:0]         data,
  output logic                     req,
  output logic [IDX_W-1:0]         idx,
  output logic [NUM_CNT*CNT_W-1:0] snap,
  output logic [SUM_W-1:0]         total,
  output logic [NUM_CNT-1:0]       err_mask,
  output logic                     busy,
  output logic                     done
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     snap_q [NUM_CNT];
  logic [CNT_W-1:0]     snap_d [NUM_CNT];
  logic [SUM_W-1:0]     total_q, total_d;
  logic [NUM_CNT-1:0]   err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 req_c;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic                 tmr_expired_c;

  cnt_poll_master_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .dec       (tmr_dec),
    .expired_c (tmr_expired_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    total_d  = total_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    req_c    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          total_d = '0;
          err_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_ISSUE: begin
        if (idle) begin
          req_c    = 1'b1;
          tmr_load = 1'b1;
          state_d  = S_WAIT;
        end
      end

      // A valid on the last permitted cycle beats the timeout.
      S_WAIT: begin
        if (valid) begin
          for (int i = 0; i < NUM_CNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              snap_d[i] = data;
            end
          end
          total_d = total_q + SUM_W'(data);
          state_d = S_NEXT;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expired_c) begin
            for (int i = 0; i < NUM_CNT; i++) begin
              if (idx_q == IDX_W'(i)) begin
                snap_d[i] = '0;
                err_d[i]  = 1'b1;
              end
            end
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_CNT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '{default: '0};
      total_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      total_q <= total_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The request strobe follows idle in the issue cycle itself.
  assign req      = req_c;
  assign idx      = idx_q;
  assign total    = total_q;
  assign err_mask = err_q;
  assign busy     = busy_q;
  assign done     = done_q;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_snap
    assign snap[snap_lsb(g, CNT_W) +: CNT_W] = snap_q[g];
  end

endmodule

// File: tb/tb_cnt_poll_master.sv
// Directed, table-driven bench for cnt_poll_master with a simple responder.
module tb_cnt_poll_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic        idle;
  logic        valid;
  logic [4:0]  data;
  logic        req;
  logic [2:0]  idx;
  logic [24:0] snap;
  logic [7:0]  total;
  logic [4:0]  err_mask;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  cnt_poll_master dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .idle     (idle),
    .valid    (valid),
    .data     (data),
    .req      (req),
    .idx      (idx),
    .snap     (snap),
    .total    (total),
    .err_mask (err_mask),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] dat;
    logic [4:0]  dead;
    int          idle_lo_at;
    int          idle_lo_len;
    int          late_idx;
    int          xs1;
    int          xs2;
    logic [24:0] exp_snap;
    logic [7:0]  exp_total;
    logic [4:0]  exp_err;
    int          exp_done;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input logic [24:0] dat, input logic [4:0] dead,
                              input int ilo_at, input int ilo_len, input int late,
                              input int xs1, input int xs2, input logic [24:0] es,
                              input logic [7:0] et, input logic [4:0] ee, input int ed);
    vec_t v;
    v.dat = dat; v.dead = dead; v.idle_lo_at = ilo_at; v.idle_lo_len = ilo_len;
    v.late_idx = late; v.xs1 = xs1; v.xs2 = xs2;
    v.exp_snap = es; v.exp_total = et; v.exp_err = ee; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One sweep: start at cycle 0, responder answers one cycle after req.
  task automatic run_vec(input int n, input vec_t v);
    int       done_at;
    int       nreq;
    int       late_ph;
    logic     prev_req;
    logic [2:0] req_idx;
    logic     order_bad;
    logic     idle_bad;
    logic     busy_bad;
    done_at = -1; nreq = 0; late_ph = 0; prev_req = 1'b0; req_idx = '0;
    order_bad = 1'b0; idle_bad = 1'b0; busy_bad = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      reset = 1'b0;
      start = (cyc == 0) || (cyc == v.xs1) || (cyc == v.xs2);
      idle  = !((cyc >= v.idle_lo_at) && (cyc < v.idle_lo_at + v.idle_lo_len));
      valid = 1'b0;
      data  = '0;
      if (prev_req && !v.dead[req_idx] && (int'(req_idx) != v.late_idx)) begin
        valid = 1'b1;
        data  = v.dat[int'(req_idx)*5 +: 5];
      end
      if (late_ph == 1) begin
        late_ph = 2;
      end else if (late_ph == 2) begin
        valid = 1'b1; data = 5'd9; late_ph = 3;
      end else if ((late_ph == 0) && (int'(idx) == v.late_idx)) begin
        valid = 1'b1; data = 5'd21;
      end
      #1;
      if (busy !== (cyc >= 1)) busy_bad = 1'b1;
      if (req === 1'b1) begin
        if (idx !== 3'(nreq)) order_bad = 1'b1;
        if (!idle) idle_bad = 1'b1;
        req_idx = idx;
        if (int'(idx) == v.late_idx) late_ph = 1;
        nreq++;
      end
      prev_req = (req === 1'b1);
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    chk($sformatf("v%0d done_cycle", n), 32'(done_at), 32'(v.exp_done));
    chk($sformatf("v%0d req_count", n), 32'(nreq), 32'd5);
    chk($sformatf("v%0d req_idx_order", n), 32'(order_bad), 32'd0);
    chk($sformatf("v%0d req_while_not_idle", n), 32'(idle_bad), 32'd0);
    chk($sformatf("v%0d busy_window", n), 32'(busy_bad), 32'd0);
    chk($sformatf("v%0d snap", n), 32'(snap), 32'(v.exp_snap));
    chk($sformatf("v%0d total", n), 32'(total), 32'(v.exp_total));
    chk($sformatf("v%0d err_mask", n), 32'(err_mask), 32'(v.exp_err));
    @(negedge clk);
    start = 1'b0; valid = 1'b0; idle = 1'b1;
    #1;
    chk($sformatf("v%0d done_pulse_width", n), 32'(done), 32'd0);
    chk($sformatf("v%0d busy_after_done", n), 32'(busy), 32'd0);
    chk($sformatf("v%0d idx_after_done", n), 32'(idx), 32'd0);
    chk($sformatf("v%0d snap_stable", n), 32'(snap), 32'(v.exp_snap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_req;
    logic stray_req;
    reset = 1'b1; start = 1'b0; idle = 1'b1; valid = 1'b0; data = '0;

    tbl[0] = mk({5'd12,5'd31,5'd0,5'd7,5'd3}, 5'b00000, -1, 0, -1, -1, -1,
                {5'd12,5'd31,5'd0,5'd7,5'd3}, 8'd53, 5'b00000, 16);
    tbl[1] = mk({5'd12,5'd31,5'd0,5'd7,5'd3}, 5'b00000, 7, 4, -1, -1, -1,
                {5'd12,5'd31,5'd0,5'd7,5'd3}, 8'd53, 5'b00000, 20);
    tbl[2] = mk({5'd12,5'd31,5'd0,5'd7,5'd3}, 5'b01000, -1, 0, -1, -1, -1,
                {5'd12,5'd0,5'd0,5'd7,5'd3}, 8'd22, 5'b01000, 23);
    tbl[3] = mk({5'd16,5'd8,5'd4,5'd2,5'd1}, 5'b00000, -1, 0, -1, 5, 16,
                {5'd16,5'd8,5'd4,5'd2,5'd1}, 8'd31, 5'b00000, 16);
    tbl[4] = mk({5'd12,5'd31,5'd0,5'd7,5'd3}, 5'b00000, -1, 0, 1, -1, -1,
                {5'd12,5'd31,5'd0,5'd9,5'd3}, 8'd55, 5'b00000, 17);
    tbl[5] = mk({5'd31,5'd31,5'd31,5'd31,5'd31}, 5'b00000, -1, 0, -1, -1, -1,
                {5'd31,5'd31,5'd31,5'd31,5'd31}, 8'd155, 5'b00000, 16);
    tbl[6] = mk({5'd31,5'd31,5'd31,5'd31,5'd31}, 5'b11111, -1, 0, -1, -1, -1,
                25'd0, 8'd0, 5'b11111, 51);

    repeat (3) @(negedge clk);
    #1;
    chk("rst req", 32'(req), 32'd0);
    chk("rst idx", 32'(idx), 32'd0);
    chk("rst snap", 32'(snap), 32'd0);
    chk("rst total", 32'(total), 32'd0);
    chk("rst err_mask", 32'(err_mask), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(i, tbl[i]);
    end

    // Reset while waiting on idx 2, then confirm a clean restart.
    prev_req = 1'b0;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      reset = (cyc == 8);
      idle  = 1'b1;
      valid = prev_req;
      data  = 5'd5;
      #1;
      prev_req = (req === 1'b1);
    end
    chk("prerst idx", 32'(idx), 32'd2);
    chk("prerst busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; valid = 1'b0;
    #1;
    chk("midrst req", 32'(req), 32'd0);
    chk("midrst idx", 32'(idx), 32'd0);
    chk("midrst snap", 32'(snap), 32'd0);
    chk("midrst total", 32'(total), 32'd0);
    chk("midrst err_mask", 32'(err_mask), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    stray_req = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      #1;
      if (req !== 1'b0 || busy !== 1'b0) stray_req = 1'b1;
    end
    chk("postrst quiet", 32'(stray_req), 32'd0);
    run_vec(7, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
